sobel_window_gen: RTL and testbench

//  Upstream stage of the Sobel gradient block: turns a raster-order 24-bit RGB pixel stream into a 3x3 pixel window.
//  Two line buffers hold the previous two rows; a 3x3 register array slides one column per accepted pixel.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_line_buffer.sv | 33 +++
 rtl/sobel_window_gen.sv | 144 ++++++++++++++
 tb/tb_sobel_window_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: pixel layout, default frame size, coordinate width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sobel_pkg;

    localparam int SOBEL_PIX_W      = 24;
    localparam int SOBEL_R_LSB      = 16;
    localparam int SOBEL_G_LSB      = 8;
    localparam int SOBEL_B_LSB      = 0;
    localparam int SOBEL_IMG_WIDTH  = 640;
    localparam int SOBEL_IMG_HEIGHT = 480;
    localparam int SOBEL_COORD_W    = 10;

    typedef logic [SOBEL_PIX_W-1:0] sobel_pix_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row pixel store: one write port, one registered read port, old data returned on address collision.
// Latency: 1 cycle read (data updates only when rd_en is high, otherwise holds).
// Backpressure: none; caller gates rd_en/wr_en with its accept strobe.
module sobel_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DAT_W  = 24,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DAT_W-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DAT_W-1:0]  rd_dat
);

    // No reset on the array or read register so the tool can map them into block RAM.
    logic [DAT_W-1:0] mem_q [DEPTH];
    logic [DAT_W-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster RGB pixel stream into a sliding 3x3 window with centre coordinates.
// Latency: 1 cycle from accepted pixel to taps/win_valid/coords/frame_done.
// Backpressure: none; pix_valid low stalls everything, the block always accepts.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = SOBEL_IMG_WIDTH,
    parameter int IMG_HEIGHT = SOBEL_IMG_HEIGHT,
    parameter int PIX_W      = SOBEL_PIX_W,
    parameter int COORD_W    = SOBEL_COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [PIX_W-1:0]   x00,
    output logic [PIX_W-1:0]   x01,
    output logic [PIX_W-1:0]   x02,
    output logic [PIX_W-1:0]   x10,
    output logic [PIX_W-1:0]   x11,
    output logic [PIX_W-1:0]   x12,
    output logic [PIX_W-1:0]   x20,
    output logic [PIX_W-1:0]   x21,
    output logic [PIX_W-1:0]   x22,
    output logic               win_valid,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               frame_done
);

    localparam int                 LB_AW    = $clog2(IMG_WIDTH);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic [COORD_W-1:0] cur_row, cur_col;
    logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [COORD_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;

    always_comb begin
        // sof forces the accepted pixel to (0,0) whatever the counters say.
        cur_row      = sof ? '0 : row_q;
        cur_col      = sof ? '0 : col_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        if (pix_valid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix_in;
            if (cur_row >= TWO && cur_col >= TWO) begin
                win_valid_d = 1'b1;
                win_row_d   = cur_row - 1'b1;
                win_col_d   = cur_col - 1'b1;
            end
            frame_done_d = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
        end
    end

    // Reads are issued one pixel ahead (next column) so the registered RAM output
    // lines up with the pixel accepted on the following cycle.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DAT_W (PIX_W),
        .ADDR_W(LB_AW)
    ) u_lb0 (
        .clk    (clk),
        .wr_en  (pix_valid),
        .wr_addr(cur_col[LB_AW-1:0]),
        .wr_dat (pix_in),
        .rd_en  (pix_valid),
        .rd_addr(col_d[LB_AW-1:0]),
        .rd_dat (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .DAT_W (PIX_W),
        .ADDR_W(LB_AW)
    ) u_lb1 (
        .clk    (clk),
        .wr_en  (pix_valid),
        .wr_addr(cur_col[LB_AW-1:0]),
        .wr_dat (lb0_rd),
        .rd_en  (pix_valid),
        .rd_addr(col_d[LB_AW-1:0]),
        .rd_dat (lb1_rd)
    );

    assign x00        = win_q[0][0];
    assign x01        = win_q[0][1];
    assign x02        = win_q[0][2];
    assign x10        = win_q[1][0];
    assign x11        = win_q[1][1];
    assign x12        = win_q[1][2];
    assign x20        = win_q[2][0];
    assign x21        = win_q[2][1];
    assign x22        = win_q[2][2];
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 5x4 frame; a 2-D frame model predicts every output cycle.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 24;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] pix_in;
    logic          pix_valid;
    logic          sof;
    logic [PW-1:0] x00, x01, x02, x10, x11, x12, x20, x21, x22;
    logic          win_valid;
    logic [CW-1:0] win_row, win_col;
    logic          frame_done;

    always #5 clk = ~clk;

    sobel_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PW),
        .COORD_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .x00       (x00),
        .x01       (x01),
        .x02       (x02),
        .x10       (x10),
        .x11       (x11),
        .x12       (x12),
        .x20       (x20),
        .x21       (x21),
        .x22       (x22),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic                 vld;
        logic                 done;
        logic [CW-1:0]        row;
        logic [CW-1:0]        col;
        logic                 tk;
        logic [8:0][PW-1:0]   taps;
    } obs_t;

    obs_t          sb [$];
    obs_t          obs_log [0:19];
    obs_t          m_state;
    logic [PW-1:0] img [H][W];
    int            m_row, m_col;
    int            n_tests = 0;
    int            n_fail  = 0;

    assert property (@(negedge clk) disable iff (!rst_n)
        win_valid |-> (win_row >= 1 && win_row <= H-2 && win_col >= 1 && win_col <= W-2))
        else $error("FAIL coord_range row=%0d col=%0d", win_row, win_col);

    function automatic logic [PW-1:0] pixval(input int r, input int c);
        logic [7:0] b;
        b = {r[3:0], c[3:0]};
        return {8'h00, b, b};
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.vld  = win_valid;
        o.done = frame_done;
        o.row  = win_row;
        o.col  = win_col;
        o.tk   = 1'b1;
        o.taps = {x22, x21, x20, x12, x11, x10, x02, x01, x00};
        return o;
    endfunction

    task automatic model_reset();
        m_row      = 0;
        m_col      = 0;
        m_state    = '0;
        m_state.tk = 1'b1;
        sb.delete();
    endtask

    // Drive one cycle and push the outputs expected right after the next rising edge.
    task automatic drive(input bit v, input bit s, input logic [PW-1:0] px);
        obs_t e;
        int   r, c;
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        pix_in    = px;
        e         = m_state;
        e.vld     = 1'b0;
        e.done    = 1'b0;
        if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = px;
            e.tk = 1'b0;
            if (r >= 2 && c >= 2) begin
                e.vld = 1'b1;
                e.tk  = 1'b1;
                e.row = CW'(r - 1);
                e.col = CW'(c - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.taps[i*3+j] = img[r-2+i][c-2+j];
            end
            e.done = (r == H-1) && (c == W-1);
            if (c == W-1) begin
                m_col = 0;
                m_row = (r == H-1) ? 0 : r + 1;
            end else begin
                m_col = c + 1;
                m_row = r;
            end
        end
        m_state = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input bit with_sof, input int stall_pct,
                             input int n_pix, output int nwin, output int ndone);
        obs_t          e, o;
        int            idx, cyc;
        bit            v;
        logic [PW-1:0] px;
        idx = 0; cyc = 0; nwin = 0; ndone = 0;
        while (idx < n_pix) begin
            v  = ($urandom_range(99) >= stall_pct);
            px = v ? pixval(idx / W, idx % W) : PW'($urandom);
            drive(v, v && with_sof && idx == 0, px);
            o = observe();
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s scoreboard empty at idx %0d", tag, idx);
            end else begin
                e = sb.pop_front();
                if (o.vld !== e.vld || o.done !== e.done || o.row !== e.row || o.col !== e.col ||
                    (e.tk && o.taps !== e.taps)) begin
                    n_fail++;
                    $display("FAIL %s idx%0d v=%0b: got vld=%0b done=%0b rc=%0d,%0d taps=%h want vld=%0b done=%0b rc=%0d,%0d taps=%h",
                             tag, idx, v, o.vld, o.done, o.row, o.col, o.taps,
                             e.vld, e.done, e.row, e.col, e.taps);
                end
            end
            if (o.vld) nwin++;
            if (o.done) ndone++;
            if (v) begin
                obs_log[idx] = o;
                idx++;
            end
            cyc++;
            if (cyc > 2000) begin
                n_fail++;
                $display("FAIL %s cycle budget expired at idx %0d", tag, idx);
                break;
            end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
        repeat (2) @(negedge clk);
        o = observe();
        n_tests++;
        if ({o.vld, o.done, o.row, o.col, o.taps} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got %h want 0", {o.vld, o.done, o.row, o.col, o.taps});
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_frame();
        int   nwin, ndone;
        obs_t o;
        run_frame("frame1", 1'b1, 0, 20, nwin, ndone);
        n_tests++;
        if (nwin !== 6) begin n_fail++; $display("FAIL frame1_windows got %0d want 6", nwin); end
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL frame1_done got %0d want 1", ndone); end
        o = obs_log[12];
        n_tests++;
        if (!o.vld || o.taps[0] !== 24'h000000 || o.taps[2] !== 24'h000202 || o.taps[4] !== 24'h001111 ||
            o.taps[6] !== 24'h002020 || o.taps[8] !== 24'h002222 || o.row !== 1 || o.col !== 1) begin
            n_fail++;
            $display("FAIL first_window got vld=%0b taps=%h rc=%0d,%0d", o.vld, o.taps, o.row, o.col);
        end
        n_tests++;
        if (obs_log[15].vld !== 1'b0 || obs_log[16].vld !== 1'b0) begin
            n_fail++;
            $display("FAIL row_wrap_border got %0b%0b want 00", obs_log[15].vld, obs_log[16].vld);
        end
        o = obs_log[17];
        n_tests++;
        if (!o.vld || o.taps[0] !== 24'h001010 || o.taps[8] !== 24'h003232 || o.row !== 2 || o.col !== 1) begin
            n_fail++;
            $display("FAIL row_wrap_window got vld=%0b x00=%h x22=%h rc=%0d,%0d want 1 001010 003232 2,1",
                     o.vld, o.taps[0], o.taps[8], o.row, o.col);
        end
    endtask

    task automatic test_end_of_frame();
        int nwin, ndone;
        run_frame("frame2_nosof", 1'b0, 0, 20, nwin, ndone);
        n_tests++;
        if (nwin !== 6 || ndone !== 1) begin
            n_fail++;
            $display("FAIL frame2 got windows=%0d done=%0d want 6 1", nwin, ndone);
        end
    endtask

    task automatic test_stall();
        int nwin, ndone;
        run_frame("stall", 1'b1, 50, 20, nwin, ndone);
        n_tests++;
        if (nwin !== 6 || ndone !== 1) begin
            n_fail++;
            $display("FAIL stall_frame got windows=%0d done=%0d want 6 1", nwin, ndone);
        end
    endtask

    task automatic test_sof_resync();
        int nwin, ndone, first;
        run_frame("partial7", 1'b1, 0, 7, nwin, ndone);
        run_frame("resync", 1'b1, 0, 20, nwin, ndone);
        first = -1;
        for (int i = 19; i >= 0; i--) if (obs_log[i].vld) first = i;
        n_tests++;
        if (nwin !== 6 || ndone !== 1 || first !== 12) begin
            n_fail++;
            $display("FAIL sof_resync got windows=%0d done=%0d first=%0d want 6 1 12", nwin, ndone, first);
        end
        run_frame("partial19", 1'b1, 0, 19, nwin, ndone);
        run_frame("sof_on_last", 1'b1, 0, 20, nwin, ndone);
        n_tests++;
        if (nwin !== 6 || ndone !== 1 || obs_log[0].done !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_on_last got windows=%0d done=%0d first_done=%0b want 6 1 0",
                     nwin, ndone, obs_log[0].done);
        end
    endtask

    task automatic test_reset_midframe();
        int   nwin, ndone;
        obs_t o;
        run_frame("pre_reset", 1'b1, 0, 13, nwin, ndone);
        @(negedge clk);
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        #1;
        o = observe();
        n_tests++;
        if ({o.vld, o.done, o.row, o.col, o.taps} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %h want 0", {o.vld, o.done, o.row, o.col, o.taps});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_frame("post_reset", 1'b1, 0, 20, nwin, ndone);
        n_tests++;
        if (nwin !== 6 || ndone !== 1 || obs_log[12].taps[4] !== 24'h001111) begin
            n_fail++;
            $display("FAIL post_reset got windows=%0d done=%0d x11=%h want 6 1 001111",
                     nwin, ndone, obs_log[12].taps[4]);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_end_of_frame();
        test_stall();
        test_sof_resync();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
